// File: rtl/freq_pkg.sv
// Shared constants and types for the programmable square-wave generator.
package freq_pkg;
  localparam int NUM_DIGITS = 8;
  localparam int ACC_W      = 27;
  localparam int unsigned MOD_10M = 10_000_000;
  localparam int unsigned MOD_50M = 50_000_000;

  typedef enum logic [1:0] {IDLE, CONV, CHECK} state_t;

  function automatic int unsigned modulus_for(input logic sel_50);
    return sel_50 ? MOD_50M : MOD_10M;
  endfunction
endpackage

// File: rtl/freq_synth_bcd_to_bin.sv
// Sequential BCD-to-binary converter: one digit per cycle, MSD first, x10 by shift-add.
module bcd_to_bin #(
  parameter int NUM_DIGITS = 8,
  parameter int ACC_W      = 27
) (
  input  logic                    fpga_clk,
  input  logic                    nreset,
  input  logic                    start,
  input  logic [NUM_DIGITS*4-1:0] digits,
  output logic                    done,
  output logic                    bad,
  output logic [ACC_W-1:0]        bin
);
  localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [NUM_DIGITS*4-1:0] sh;
  logic [CW-1:0]           idx;
  logic                    run;
  logic [3:0]              d;

  assign d    = sh[NUM_DIGITS*4-1 -: 4];
  // high during the cycle that consumes the last digit; bin/bad are final right after
  assign done = run && (idx == CW'(NUM_DIGITS-1));

  always_ff @(posedge fpga_clk or negedge nreset) begin
    if (!nreset) begin
      sh  <= '0;
      idx <= '0;
      run <= 1'b0;
      bad <= 1'b0;
      bin <= '0;
    end else if (start) begin
      sh  <= digits;
      idx <= '0;
      run <= 1'b1;
      bad <= 1'b0;
      bin <= '0;
    end else if (run) begin
      bin <= (bin << 3) + (bin << 1) + ACC_W'(d);
      bad <= bad | (d > 4'd9);
      sh  <= sh << 4;
      idx <= idx + 1'b1;
      if (done) run <= 1'b0;
    end
  end
endmodule

// File: rtl/freq_synth.sv
// BCD setpoint load/convert/check plus modulus-M phase accumulator square-wave generator.
module freq_synth #(
  parameter int NUM_DIGITS = freq_pkg::NUM_DIGITS,
  parameter int ACC_W      = freq_pkg::ACC_W
) (
  input  logic             fpga_clk,
  input  logic             nreset,
  input  logic             n10_50,
  input  logic [3:0]       digit_in,
  input  logic             digit_wr,
  input  logic             commit,
  input  logic             enable,
  output logic             sig_out,
  output logic             busy,
  output logic             err,
  output logic [ACC_W-1:0] freq_bin
);
  import freq_pkg::*;

  state_t                  state, state_nx;
  logic [NUM_DIGITS*4-1:0] staging;
  logic                    start, accept, reject, sel_q;
  logic                    conv_done, conv_bad;
  logic [ACC_W-1:0]        conv_bin, m_new, modulus, acc, sum;

  bcd_to_bin #(.NUM_DIGITS(NUM_DIGITS), .ACC_W(ACC_W)) u_conv (
    .fpga_clk (fpga_clk),
    .nreset   (nreset),
    .start    (start),
    .digits   (staging),
    .done     (conv_done),
    .bad      (conv_bad),
    .bin      (conv_bin)
  );

  assign m_new = ACC_W'(modulus_for(sel_q));

  always_ff @(posedge fpga_clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (commit) state_nx = CONV;
      CONV:    if (conv_done) state_nx = CHECK;
      CHECK:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    start  = (state == IDLE) && commit;
    accept = (state == CHECK) && !conv_bad && (conv_bin <= (m_new >> 1));
    reject = (state == CHECK) && !accept;
  end

  // commit beats a same-cycle digit write; writes outside IDLE are dropped
  always_ff @(posedge fpga_clk or negedge nreset) begin
    if (!nreset) begin
      staging <= '0;
      sel_q   <= 1'b0;
    end else if (start) begin
      sel_q   <= n10_50;
    end else if (digit_wr && state == IDLE) begin
      staging <= (NUM_DIGITS*4)'({staging, digit_in});
    end
  end

  always_ff @(posedge fpga_clk or negedge nreset) begin
    if (!nreset) begin
      freq_bin <= '0;
      modulus  <= ACC_W'(MOD_10M);
      err      <= 1'b0;
    end else if (accept) begin
      freq_bin <= conv_bin;
      modulus  <= m_new;
      err      <= 1'b0;
    end else if (reject) begin
      err      <= 1'b1;
    end
  end

  // s = acc + 2f; acc < M and 2f <= M keeps s below 2M, so one subtract suffices
  assign sum = acc + (freq_bin << 1);

  always_ff @(posedge fpga_clk or negedge nreset) begin
    if (!nreset) begin
      acc     <= '0;
      sig_out <= 1'b0;
    end else if (!enable) begin
      acc     <= '0;
      sig_out <= 1'b0;
    end else if (accept) begin
      acc     <= '0;
    end else if (sum >= modulus) begin
      acc     <= sum - modulus;
      sig_out <= ~sig_out;
    end else begin
      acc     <= sum;
    end
  end
endmodule

// File: tb/tb_freq_synth.sv
// Self-checking bench for freq_synth: toggle-count reference model, vector table, directed corners, random setpoints.
`timescale 1ns/1ps
module tb_freq_synth;
  localparam int ND = 8;
  localparam int AW = 27;

  logic          fpga_clk = 1'b0;
  logic          nreset   = 1'b0;
  logic          n10_50   = 1'b0;
  logic [3:0]    digit_in = 4'd0;
  logic          digit_wr = 1'b0;
  logic          commit   = 1'b0;
  logic          enable   = 1'b0;
  logic          sig_out, busy, err;
  logic [AW-1:0] freq_bin;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  always #5 fpga_clk = ~fpga_clk;

  freq_synth #(.NUM_DIGITS(ND), .ACC_W(AW)) dut (
    .fpga_clk (fpga_clk),
    .nreset   (nreset),
    .n10_50   (n10_50),
    .digit_in (digit_in),
    .digit_wr (digit_wr),
    .commit   (commit),
    .enable   (enable),
    .sig_out  (sig_out),
    .busy     (busy),
    .err      (err),
    .freq_bin (freq_bin)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: after n enabled cycles from a zeroed phase the output has toggled floor(n*2f/M) times.
  int     m_stage[ND];
  int     m_left;
  bit     m_pok, m_base, m_sig, m_err;
  longint m_pval, m_pm, m_f, m_m, m_n;

  function automatic longint stage_val();
    longint v = 0;
    for (int i = 0; i < ND; i++) v = v * 10 + m_stage[i];
    return v;
  endfunction

  function automatic bit stage_bad();
    for (int i = 0; i < ND; i++) if (m_stage[i] > 9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit odd_toggles(input longint n, input longint f, input longint m);
    return bit'(((n * 2 * f) / m) % 2);
  endfunction

  always @(posedge fpga_clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < ND; i++) m_stage[i] <= 0;
      m_left <= 0; m_pok <= 1'b0; m_pval <= 0; m_pm <= 10000000;
      m_f <= 0; m_m <= 10000000; m_n <= 0; m_base <= 1'b0; m_sig <= 1'b0; m_err <= 1'b0;
    end else begin
      if (m_left == 0 && commit) begin
        m_left <= 9;
        m_pm   <= n10_50 ? 64'd50000000 : 64'd10000000;
        m_pval <= stage_val();
        m_pok  <= !stage_bad() && (stage_val() <= (n10_50 ? 64'd25000000 : 64'd5000000));
      end else begin
        if (m_left == 0 && digit_wr) begin
          for (int i = 0; i < ND-1; i++) m_stage[i] <= m_stage[i+1];
          m_stage[ND-1] <= int'(digit_in);
        end
        if (m_left > 0) m_left <= m_left - 1;
      end
      if (m_left == 1) begin
        if (m_pok) begin m_f <= m_pval; m_m <= m_pm; m_err <= 1'b0; end
        else m_err <= 1'b1;
      end
      if (!enable) begin
        m_n <= 0; m_base <= 1'b0; m_sig <= 1'b0;
      end else if (m_left == 1 && m_pok) begin
        m_n <= 0; m_base <= m_sig;
      end else begin
        m_n   <= m_n + 1;
        m_sig <= m_base ^ odd_toggles(m_n + 1, m_f, m_m);
      end
    end
  end

  always @(negedge fpga_clk) begin
    if (chk_on) begin
      check("sig_out", sig_out, m_sig);
      check("busy", busy, m_left > 0);
      check("err", err, m_err);
      check("freq_bin", freq_bin, m_f);
    end
  end

  task automatic tick();
    @(negedge fpga_clk);
  endtask

  task automatic write_digits(input logic [31:0] bcd);
    for (int i = ND-1; i >= 0; i--) begin
      digit_in = bcd[i*4 +: 4];
      digit_wr = 1'b1;
      tick();
    end
    digit_wr = 1'b0;
  endtask

  task automatic do_commit(input bit sel, output int bcnt);
    n10_50 = sel;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    bcnt = 0;
    while (busy && bcnt < 30) begin bcnt++; tick(); end
  endtask

  function automatic logic [31:0] to_bcd(input longint v);
    logic [31:0] r = '0;
    longint x = v;
    for (int i = 0; i < ND; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  typedef struct {
    bit          sel;
    logic [31:0] bcd;
    bit          e_err;
    int          e_freq;
  } vec_t;

  vec_t vt[9];
  bit   tgl[50000];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, first, tg, hi, ones, total, last, mn, mx, win, badwin, found, idx;
    bit prev, sel;
    logic [31:0] bcd;
    longint v, half;

    vt[0] = '{1'b0, 32'h00100000, 1'b0, 100000};
    vt[1] = '{1'b0, 32'h000A0000, 1'b1, 100000};
    vt[2] = '{1'b0, 32'h0500000F, 1'b1, 100000};
    vt[3] = '{1'b1, 32'h25000000, 1'b0, 25000000};
    vt[4] = '{1'b1, 32'h25000001, 1'b1, 25000000};
    vt[5] = '{1'b0, 32'h05000001, 1'b1, 25000000};
    vt[6] = '{1'b0, 32'h00000000, 1'b0, 0};
    vt[7] = '{1'b1, 32'h99999999, 1'b1, 0};
    vt[8] = '{1'b0, 32'h00001234, 1'b0, 1234};

    // reset values
    repeat (3) tick();
    check("rst_sig_out", sig_out, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_freq_bin", freq_bin, 0);
    nreset = 1'b1;
    chk_on = 1'b1;
    enable = 1'b1;
    ones = 0;
    repeat (20) begin tick(); ones += int'(sig_out); end
    check("idle_static_high_cycles", ones, 0);

    // 100 kHz at M = 10M: 50 high / 50 low, first toggle on 50th enabled cycle
    write_digits(32'h00100000);
    do_commit(1'b0, b);
    check("busy_len_100k", b, 9);
    check("freq_100k", freq_bin, 100000);
    first = 0; tg = 0; hi = 0; prev = sig_out;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (sig_out != prev) begin tg++; if (first == 0) first = i; end
      prev = sig_out;
      hi += int'(sig_out);
    end
    check("first_toggle_cycle", first, 50);
    check("toggles_300", tg, 6);
    check("high_cycles_300", hi, 150);

    // M/2 boundary
    write_digits(32'h05000000);
    do_commit(1'b0, b);
    check("freq_5M", freq_bin, 5000000);
    tg = 0; prev = sig_out;
    repeat (20) begin tick(); if (sig_out != prev) tg++; prev = sig_out; end
    check("toggle_every_cycle", tg, 20);
    write_digits(32'h05000001);
    do_commit(1'b0, b);
    check("err_over_half", err, 1);
    check("freq_kept_5M", freq_bin, 5000000);
    write_digits(32'h00000001);
    do_commit(1'b0, b);
    check("err_cleared", err, 0);
    check("freq_1", freq_bin, 1);

    foreach (vt[i]) begin
      write_digits(vt[i].bcd);
      do_commit(vt[i].sel, b);
      check($sformatf("vec%0d_busy_len", i), b, 9);
      check($sformatf("vec%0d_err", i), err, vt[i].e_err);
      check($sformatf("vec%0d_freq", i), freq_bin, vt[i].e_freq);
    end

    // 3 MHz at M = 50M: 6 toggles per 50 cycles, intervals 8..9
    write_digits(32'h03000000);
    do_commit(1'b1, b);
    check("freq_3M", freq_bin, 3000000);
    total = 0; last = -1; mn = 1000; mx = 0; prev = sig_out;
    for (int i = 0; i < 50000; i++) begin
      tick();
      tgl[i] = (sig_out != prev);
      prev = sig_out;
      if (tgl[i]) begin
        total++;
        if (last >= 0) begin
          if (i - last < mn) mn = i - last;
          if (i - last > mx) mx = i - last;
        end
        last = i;
      end
    end
    win = 0; badwin = 0;
    for (int i = 0; i < 50; i++) win += int'(tgl[i]);
    if (win != 6) badwin++;
    for (int i = 50; i < 50000; i++) begin
      win += int'(tgl[i]) - int'(tgl[i-50]);
      if (win != 6) badwin++;
    end
    check("toggles_50000", total, 6000);
    check("windows_not_6", badwin, 0);
    check("min_interval", mn, 8);
    check("max_interval", mx, 9);

    // commit and digit_wr during busy are ignored
    write_digits(32'h00000010);
    n10_50 = 1'b0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    b = 0;
    while (busy && b < 30) begin
      b++;
      digit_in = 4'd9;
      digit_wr = (b >= 2 && b <= 5);
      commit   = (b == 3 || b == 9);
      tick();
    end
    digit_wr = 1'b0; commit = 1'b0;
    check("busy_len_with_noise", b, 9);
    check("freq_10", freq_bin, 10);
    ones = 0;
    repeat (3) begin tick(); ones += int'(busy); end
    check("no_restart_busy", ones, 0);
    do_commit(1'b0, b);
    check("staging_unchanged_freq", freq_bin, 10);

    // enable drop while high
    write_digits(32'h01000000);
    do_commit(1'b0, b);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin tick(); if (sig_out) found = 1; end
    check("saw_high", found, 1);
    enable = 1'b0;
    tick();
    check("enable_drop_low", sig_out, 0);
    enable = 1'b1;
    repeat (5) tick();

    // reset mid-conversion
    write_digits(32'h09999999);
    do_commit(1'b0, b);
    check("err_before_reset", err, 1);
    write_digits(32'h00500000);
    n10_50 = 1'b0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    repeat (3) tick();
    chk_on = 1'b0;
    #2 nreset = 1'b0;
    #1;
    check("midconv_rst_busy", busy, 0);
    check("midconv_rst_err", err, 0);
    check("midconv_rst_freq", freq_bin, 0);
    check("midconv_rst_sig", sig_out, 0);
    tick();
    #2 nreset = 1'b1;
    tick();
    chk_on = 1'b1;
    write_digits(32'h00001000);
    do_commit(1'b0, b);
    check("post_rst_busy_len", b, 9);
    check("post_rst_freq", freq_bin, 1000);

    // random setpoints, noise and enable flips against the reference model
    for (int it = 0; it < 40; it++) begin
      sel  = bit'($urandom_range(0, 1));
      half = sel ? 64'd25000000 : 64'd5000000;
      case ($urandom_range(0, 4))
        0: v = half;
        1: v = half + 1;
        2: v = longint'($urandom_range(0, 32'(half)));
        3: v = longint'($urandom_range(0, 99999999));
        default: v = longint'($urandom_range(0, 2000));
      endcase
      bcd = to_bcd(v);
      if ($urandom_range(0, 5) == 0) begin
        idx = int'($urandom_range(0, ND-1));
        bcd[idx*4 +: 4] = 4'($urandom_range(10, 15));
      end
      write_digits(bcd);
      n10_50 = sel;
      commit = 1'b1;
      tick();
      commit = 1'b0;
      b = 0;
      while (busy && b < 30) begin
        b++;
        digit_in = 4'($urandom_range(0, 15));
        digit_wr = bit'($urandom_range(0, 1));
        commit   = bit'($urandom_range(0, 1));
        n10_50   = bit'($urandom_range(0, 1));
        tick();
      end
      digit_wr = 1'b0; commit = 1'b0;
      check($sformatf("rand%0d_busy_len", it), b, 9);
      repeat ($urandom_range(1, 60)) begin
        enable = ($urandom_range(0, 7) != 0);
        tick();
      end
      enable = 1'b1;
    end

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
